// File: rtl/cr16_alu.sv
// rtl/cr16_alu.sv - CR16-style 16-bit ALU with optional status hold register
//
// Purpose: combinational 16-bit ALU (add/sub with signed and unsigned flag
// variants, bitwise logic, shifts). It has an optional status register that
// holds the last enabled flags while the ALU is disabled.
//
// Optional feature macro: CR16_ALU_STATUS_HOLD_EN
//   defined   - status register built; O_STATUS shows it while I_ENABLE=0
//   undefined - no register; O_STATUS=0 while I_ENABLE=0; I_CLK/I_RESET unused
//
// Ports:
//   I_CLK     in   1   clock for the status register
//   I_RESET   in   1   synchronous active-high reset of the status register
//   I_ENABLE  in   1   1 = outputs follow the operation result
//   I_A       in  16   operand A (subtrahend, shifted value)
//   I_B       in  16   operand B (minuend, shift amount)
//   I_OPCODE  in   4   operation select
//   O_C       out 16   result
//   O_STATUS  out  5   {N, Z, F, L, C}
module cr16_alu (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  input  logic [3:0]  I_OPCODE,
  output logic [15:0] O_C,
  output logic [4:0]  O_STATUS
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_ADDU  = 4'd1;
  localparam logic [3:0] OP_ADDC  = 4'd2;
  localparam logic [3:0] OP_ADDCU = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_OR    = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LSH   = 4'd10;
  localparam logic [3:0] OP_RSH   = 4'd11;
  localparam logic [3:0] OP_ALSH  = 4'd12;
  localparam logic [3:0] OP_ARSH  = 4'd13;

  logic        carry_in;
  logic [16:0] add_sum;
  logic [16:0] sub_diff;
  logic        add_ovf;
  logic        sub_ovf;
  logic [15:0] result;
  logic        c_flag;
  logic        l_flag;
  logic        f_flag;
  logic        n_flag;
  logic [4:0]  comb_status;
  logic [4:0]  held_status;

  // Opcodes 2 and 3 are the carry-in variants; bit 1 selects the +1.
  assign carry_in = I_OPCODE[1];
  assign add_sum  = {1'b0, I_A} + {1'b0, I_B} + {16'b0, carry_in};
  // Bit 16 of the extended difference is the unsigned borrow (B < A).
  assign sub_diff = {1'b0, I_B} - {1'b0, I_A};

  assign add_ovf = (I_A[15] == I_B[15]) && (add_sum[15] != I_A[15]);
  assign sub_ovf = (I_A[15] != I_B[15]) && (sub_diff[15] != I_B[15]);

  always_comb begin
    result = '0;
    c_flag = 1'b0;
    l_flag = 1'b0;
    f_flag = 1'b0;
    n_flag = 1'b0;
    case (I_OPCODE)
      OP_ADD, OP_ADDC: begin
        result = add_sum[15:0];
        f_flag = add_ovf;
        n_flag = add_sum[15];
      end
      OP_ADDU, OP_ADDCU: begin
        result = add_sum[15:0];
        c_flag = add_sum[16];
      end
      OP_SUB: begin
        result = sub_diff[15:0];
        f_flag = sub_ovf;
        // True signed B < A: the result sign, corrected when it overflowed.
        n_flag = sub_diff[15] ^ sub_ovf;
      end
      OP_SUBU: begin
        result = sub_diff[15:0];
        c_flag = sub_diff[16];
        l_flag = sub_diff[16];
      end
      OP_AND:          result = I_A & I_B;
      OP_OR:           result = I_A | I_B;
      OP_XOR:          result = I_A ^ I_B;
      OP_NOT:          result = ~I_A;
      // Shifts by the full 16-bit amount, so B >= 16 naturally yields
      // zero (or all sign bits for ARSH).
      OP_LSH, OP_ALSH: result = I_A << I_B;
      OP_RSH:          result = I_A >> I_B;
      OP_ARSH:         result = $signed(I_A) >>> I_B;
      default:         result = '0;
    endcase
  end

  assign comb_status = {n_flag, (result == 16'd0), f_flag, l_flag, c_flag};

`ifdef CR16_ALU_STATUS_HOLD_EN
  logic [4:0] status_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      status_q <= '0;
    end else if (I_ENABLE) begin
      status_q <= comb_status;
    end
  end

  assign held_status = status_q;
`else
  // Clock and reset have no load in this build.
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, I_CLK, I_RESET};
  assign held_status    = '0;
`endif

  assign O_C      = I_ENABLE ? result      : 16'd0;
  assign O_STATUS = I_ENABLE ? comb_status : held_status;

endmodule

// File: tb/tb_cr16_alu.sv
// tb/tb_cr16_alu.sv - scoreboard testbench for cr16_alu
module tb_cr16_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  op;
  logic [15:0] out_c;
  logic [4:0]  out_status;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] c;
    logic [4:0]  st;
    string       name;
  } exp_t;

  exp_t scoreboard[$];

  // Status register as seen by the bench: value latched by the last edge.
  logic [4:0] model_reg = 5'b0;

  always #5 clk = ~clk;

  cr16_alu dut (
    .I_CLK    (clk),
    .I_RESET  (rst),
    .I_ENABLE (en),
    .I_A      (a),
    .I_B      (b),
    .I_OPCODE (op),
    .O_C      (out_c),
    .O_STATUS (out_status)
  );

  // Reference ALU in plain integer arithmetic.
  function automatic void ref_alu(input logic [15:0] ra, input logic [15:0] rb,
                                  input logic [3:0] rop,
                                  output logic [15:0] rc, output logic [4:0] rst_o);
    longint sa, sb, ua, ub, r, d;
    bit cf, lf, ff, nf;
    sa = longint'($signed(ra));
    sb = longint'($signed(rb));
    ua = longint'(ra);
    ub = longint'(rb);
    cf = 0; lf = 0; ff = 0; nf = 0; r = 0;
    case (rop)
      4'd0: begin r = sa + sb;     ff = (r > 32767 || r < -32768); end
      4'd1: begin r = ua + ub;     cf = (r > 65535); end
      4'd2: begin r = sa + sb + 1; ff = (r > 32767 || r < -32768); end
      4'd3: begin r = ua + ub + 1; cf = (r > 65535); end
      4'd4: begin r = sb - sa;     ff = (r > 32767 || r < -32768); nf = (sb < sa); end
      4'd5: begin r = ub - ua;     cf = (ub < ua); lf = cf; end
      4'd6: r = longint'(ra & rb);
      4'd7: r = longint'(ra | rb);
      4'd8: r = longint'(ra ^ rb);
      4'd9: r = longint'(~ra);
      4'd10, 4'd12: r = (ub >= 16) ? 0 : ua * (longint'(1) << ub);
      4'd11: r = (ub >= 16) ? 0 : ua / (longint'(1) << ub);
      4'd13: begin
        if (ub >= 16) r = (sa < 0) ? -1 : 0;
        else begin
          d = longint'(1) << ub;
          r = (sa >= 0) ? sa / d : -((-sa + d - 1) / d);
        end
      end
      default: r = 0;
    endcase
    rc = 16'(r);
    if (rop == 4'd0 || rop == 4'd2) nf = (rc >= 16'h8000);
    rst_o = {nf, (rc == 16'd0), ff, lf, cf};
  endfunction

  function automatic logic [4:0] disabled_status();
`ifdef CR16_ALU_STATUS_HOLD_EN
    return model_reg;
`else
    return 5'b0;
`endif
  endfunction

  task automatic drive(input bit d_en, input bit d_rst, input logic [3:0] d_op,
                       input logic [15:0] d_a, input logic [15:0] d_b,
                       input bit use_const, input logic [15:0] kc,
                       input logic [4:0] ks, input string name);
    exp_t e;
    logic [15:0] mc;
    logic [4:0]  ms;
    @(posedge clk);
    #1;
    en = d_en; rst = d_rst; op = d_op; a = d_a; b = d_b;
    ref_alu(d_a, d_b, d_op, mc, ms);
    if (use_const) begin
      e.c = kc; e.st = ks;
    end else if (d_en) begin
      e.c = mc; e.st = ms;
    end else begin
      e.c = 16'd0; e.st = disabled_status();
    end
    e.name = name;
    scoreboard.push_back(e);
    if (d_rst) model_reg = 5'b0;
    else if (d_en) model_reg = e.st;
  endtask

  // Monitor: outputs are combinational, so the vector is stable by the
  // falling edge of the cycle in which it was driven.
  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      exp_t e;
      e = scoreboard.pop_front();
      checks++;
      if (out_c !== e.c || out_status !== e.st) begin
        errors++;
        $display("FAIL %s: O_C=%h O_STATUS=%b expected O_C=%h O_STATUS=%b op=%0d a=%h b=%h en=%b",
                 e.name, out_c, out_status, e.c, e.st, op, a, b, en);
      end
    end
  end

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_a, r_b;
    bit          r_en, r_rst;
    int          wait_cycles;
    logic [4:0]  hold_exp;

    en = 1'b1; rst = 1'b1; op = 4'd0; a = 16'd0; b = 16'd0;

    drive(1, 1, 4'd0, 16'h1234, 16'h1111, 0, 16'd0, 5'd0, "reset_comb");
    drive(0, 0, 4'd0, 16'h1234, 16'h1111, 1, 16'd0, 5'd0, "reset_state");

    drive(1, 0, 4'd0,  16'h7FFF, 16'h0001, 1, 16'h8000, 5'b10100, "add_ovf");
    drive(1, 0, 4'd1,  16'hFC00, 16'h0400, 1, 16'h0000, 5'b01001, "addu_carry");
    drive(1, 0, 4'd3,  16'hFFFF, 16'h0000, 1, 16'h0000, 5'b01001, "addcu_carry");
    drive(1, 0, 4'd2,  16'h7FFF, 16'h0000, 1, 16'h8000, 5'b10100, "addc_ovf");
    drive(1, 0, 4'd4,  16'h0005, 16'h0003, 1, 16'hFFFE, 5'b10000, "sub_neg");
    drive(1, 0, 4'd5,  16'h0005, 16'h0003, 1, 16'hFFFE, 5'b00011, "subu_borrow");
    drive(1, 0, 4'd10, 16'h8001, 16'd1,    1, 16'h0002, 5'b00000, "lsh_1");
    drive(1, 0, 4'd11, 16'h8001, 16'd15,   1, 16'h0001, 5'b00000, "rsh_15");
    drive(1, 0, 4'd13, 16'h8001, 16'd4,    1, 16'hF800, 5'b00000, "arsh_4");
    drive(1, 0, 4'd13, 16'h8001, 16'd20,   1, 16'hFFFF, 5'b00000, "arsh_20");
    drive(1, 0, 4'd10, 16'h8001, 16'd16,   1, 16'h0000, 5'b01000, "lsh_16");
    drive(1, 0, 4'd12, 16'h8001, 16'hFFFF, 1, 16'h0000, 5'b01000, "alsh_big");
    drive(1, 0, 4'd6,  16'hF0F0, 16'h0FF0, 1, 16'h00F0, 5'b00000, "and");
    drive(1, 0, 4'd7,  16'hF0F0, 16'h0FF0, 1, 16'hFFF0, 5'b00000, "or");
    drive(1, 0, 4'd8,  16'hF0F0, 16'h0FF0, 1, 16'hFF00, 5'b00000, "xor");
    drive(1, 0, 4'd9,  16'hF0F0, 16'h0FF0, 1, 16'h0F0F, 5'b00000, "not");
    drive(1, 0, 4'd14, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 5'b01000, "undef_14");
    drive(1, 0, 4'd15, 16'h1234, 16'h5678, 1, 16'h0000, 5'b01000, "undef_15");

`ifdef CR16_ALU_STATUS_HOLD_EN
    hold_exp = 5'b00011;
`else
    hold_exp = 5'b00000;
`endif
    drive(1, 0, 4'd5, 16'h0005, 16'h0003, 1, 16'hFFFE, 5'b00011, "hold_load");
    drive(0, 0, 4'd0, 16'hAAAA, 16'h5555, 1, 16'h0000, hold_exp, "hold_keep");
    drive(0, 1, 4'd1, 16'hFFFF, 16'hFFFF, 1, 16'h0000, hold_exp, "hold_pre_reset");
    drive(0, 0, 4'd1, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 5'b00000, "hold_post_reset");
    drive(1, 1, 4'd4, 16'h8000, 16'h0001, 1, 16'h8001, 5'b00100, "reset_no_comb_effect");

    for (int i = 0; i < 400; i++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = 16'($urandom);
      r_b   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) r_a = {$urandom_range(0, 1) == 1, 15'h7FFF};
      r_en  = ($urandom_range(0, 4) != 0);
      r_rst = ($urandom_range(0, 19) == 0);
      drive(r_en, r_rst, r_op, r_a, r_b, 0, 16'd0, 5'd0, "random");
    end

    wait_cycles = 0;
    while (scoreboard.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (scoreboard.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", scoreboard.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cr16_alu.md
CR16_ALU -- requirements
Module: cr16_alu

Interface
REQ-001 SHALL: I_CLK  input  1  single clock; status register updates on its rising edge.
REQ-002 SHALL: I_RESET  input  1  synchronous, active-high reset sampled on the I_CLK rising edge.
REQ-003 SHALL: I_ENABLE  input  1  enables the ALU; 1 = outputs follow the operation result.
REQ-004 SHALL: I_A  input  16  operand A (subtrahend for SUB/SUBU; shifted value for shifts).
REQ-005 SHALL: I_B  input  16  operand B (minuend for SUB/SUBU; shift amount for shifts).
REQ-006 SHALL: I_OPCODE  input  4  operation select.
REQ-007 SHALL: O_C  output  16  result.
REQ-008 SHALL: O_STATUS  output  5  flags: [0] C carry/borrow, [1] L low, [2] F signed overflow, [3] Z zero, [4] N negative.

Function
REQ-009 SHALL: with I_ENABLE=1, O_C and O_STATUS are combinational from I_A, I_B and I_OPCODE, with zero-cycle latency.
REQ-010 SHALL: opcode 0 ADD: O_C=A+B (mod 2^16); F=signed overflow (operand signs equal, result sign differs); N=O_C[15]; C=L=0.
REQ-011 SHALL: opcode 1 ADDU: O_C=A+B (mod 2^16); C=carry out of bit 15; F=N=L=0.
REQ-012 SHALL: opcode 2 ADDC: O_C=A+B+1 (constant carry-in of 1); F=signed overflow of the 17-bit signed sum; N=O_C[15]; C=L=0.
REQ-013 SHALL: opcode 3 ADDCU: O_C=A+B+1; C=1 when A+B+1 > 65535; F=N=L=0.
REQ-014 SHALL: opcode 4 SUB: O_C=B-A; F=1 when A[15]!=B[15] and O_C[15]!=B[15]; N=1 when signed B < signed A; C=L=0.
REQ-015 SHALL: opcode 5 SUBU: O_C=B-A (mod 2^16); C=L=1 when unsigned B < unsigned A; F=N=0.
REQ-016 SHALL: opcodes 6 AND, 7 OR and 8 XOR compute the bitwise A op B; opcode 9 NOT computes ~A and ignores B.
REQ-017 SHALL: opcode 10 LSH and opcode 12 ALSH compute A shifted left by unsigned B, zero fill; B>=16 gives 0.
REQ-018 SHALL: opcode 11 RSH computes A shifted logically right by unsigned B; B>=16 gives 0.
REQ-019 SHALL: opcode 13 ARSH computes A shifted arithmetically right by unsigned B, filling with A[15]; B>=16 gives 16 copies of A[15].
REQ-020 SHALL: for every opcode, Z=1 exactly when O_C==0.
REQ-021 SHALL: opcodes 6-13 drive C=L=F=N=0.
REQ-022 SHALL: opcodes 14-15 are undefined: O_C=0 and O_STATUS=5'b01000 (Z set).
REQ-023 SHALL: with I_ENABLE=0, O_C=0 and O_STATUS is as given under Configuration.
REQ-024 SHALL: a status register captures the combinational O_STATUS on each rising I_CLK edge where I_ENABLE=1 and I_RESET=0.

Reset
REQ-025 SHALL: I_RESET=1 at a rising edge clears the status register to 5'b00000; reset has priority over capture.
REQ-026 SHALL: reset does not affect the combinational O_C or the combinational O_STATUS while I_ENABLE=1.
REQ-027 SHALL: after reset with I_ENABLE=0, O_C=0 and O_STATUS=0.

Configuration
REQ-028 SHALL: macro CR16_ALU_STATUS_HOLD_EN controls the status register.
REQ-029 SHALL: with CR16_ALU_STATUS_HOLD_EN defined, O_STATUS outputs the status register while I_ENABLE=0.
REQ-030 SHALL: with CR16_ALU_STATUS_HOLD_EN undefined, the status register is not built, O_STATUS=0 while I_ENABLE=0, and I_CLK/I_RESET are unused.

Verification
REQ-031 SHALL: ADD with A=16'h7FFF, B=16'h0001 -> O_C=16'h8000, F=1, N=1, Z=0, C=0.
REQ-032 SHALL: ADDU with A=16'hFC00, B=16'h0400 -> O_C=0, C=1, Z=1, N=0, F=0; ADDCU with A=16'hFFFF, B=0 -> O_C=0, C=1, Z=1.
REQ-033 SHALL: SUB with A=5, B=3 -> O_C=16'hFFFE, N=1, F=0, C=0, L=0; SUBU with A=5, B=3 -> O_C=16'hFFFE, C=1, L=1, N=0.
REQ-034 SHALL: shifts with A=16'h8001 -> LSH B=1 gives 16'h0002; RSH B=15 gives 16'h0001; ARSH B=4 gives 16'hF800; ARSH B=20 gives 16'hFFFF; LSH B=16 gives 0 with Z=1.
REQ-035 SHALL: logic ops with A=16'hF0F0, B=16'h0FF0 -> AND 16'h00F0, OR 16'hFFF0, XOR 16'hFF00, NOT 16'h0F0F.
REQ-036 SHALL: with CR16_ALU_STATUS_HOLD_EN defined, run SUBU A=5, B=3 for one clock, drop I_ENABLE -> O_STATUS holds 5'b00011; assert I_RESET for one edge -> O_STATUS=0.
